// File: rtl/motor_cmd_scheduler.sv
// Motor command scheduler.
// Picks one UART JSON command sender at a time and releases it from reset. It waits for that
// sender's ready flag, then holds the sender in reset again and keeps the line idle for a gap.
// The active command is re-sent as a heartbeat when no new request arrives.
module motor_cmd_scheduler #(
    parameter int unsigned NUM_CMDS     = 4,
    parameter int unsigned CMD_W        = 2,
    parameter int unsigned RESEND_CLKS  = 12_500_000,
    parameter int unsigned TIMEOUT_CLKS = 5_000_000,
    parameter int unsigned MIN_GAP_CLKS = 50_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CMD_W-1:0]    cmd_req,
    input  logic                cmd_req_valid,
    input  logic [NUM_CMDS-1:0] sender_ready,
    output logic [NUM_CMDS-1:0] sender_rst,
    output logic [CMD_W-1:0]    uart_sel,
    output logic [CMD_W-1:0]    cmd_current,
    output logic                busy,
    output logic                timeout_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] SEND   = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    // A freshly released sender may still show a stale ready flag; ignore it this many cycles.
    localparam int unsigned MASK_CLKS = 2;

    localparam int unsigned HB_W  = $clog2(RESEND_CLKS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned GAP_W = $clog2(MIN_GAP_CLKS + 1);

    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(RESEND_CLKS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [TMO_W-1:0] TMO_MASK = TMO_W'(MASK_CLKS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP_CLKS - 1);

    logic [1:0]          state_q, state_d;
    logic                pending_q, pending_d;
    logic [CMD_W-1:0]    pending_cmd_q, pending_cmd_d;
    logic [CMD_W-1:0]    cmd_current_q, cmd_current_d;
    logic [CMD_W-1:0]    uart_sel_q, uart_sel_d;
    logic [NUM_CMDS-1:0] sender_rst_q, sender_rst_d;
    logic                timeout_err_q, timeout_err_d;
    logic [HB_W-1:0]     hb_cnt_q, hb_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic                req_in_range;
    logic                req_take;
    logic                sel_ready;
    logic                ready_unmasked;
    logic [CMD_W-1:0]    commit_cmd;
    logic [NUM_CMDS-1:0] launch_mask;

    // Request qualification and release mask for the selected sender.
    always_comb begin
        req_in_range = cmd_req_valid && (32'(cmd_req) < NUM_CMDS);
        // An idle repeat of the active command is redundant: the heartbeat already covers it.
        req_take     = req_in_range &&
                       !((state_q == IDLE) && !pending_q && (cmd_req == cmd_current_q));
        // Same-cycle request beats the older pending one, so a request seen in IDLE is
        // committed on the very edge that samples it.
        commit_cmd   = req_take ? cmd_req : pending_cmd_q;
        sel_ready    = sender_ready[uart_sel_q];
        ready_unmasked = (tmo_cnt_q >= TMO_MASK) && sel_ready;
        launch_mask  = '1;
        for (int unsigned i = 0; i < NUM_CMDS; i++) begin
            launch_mask[i] = (uart_sel_q != CMD_W'(i));
        end
    end

    // Next-state logic for the frame sequencer, request queue and counters.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        pending_cmd_d = pending_cmd_q;
        cmd_current_d = cmd_current_q;
        uart_sel_d    = uart_sel_q;
        sender_rst_d  = sender_rst_q;
        timeout_err_d = timeout_err_q;
        hb_cnt_d      = hb_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        gap_cnt_d     = gap_cnt_q;

        // Capture in any state; last request wins.
        if (req_take) begin
            pending_d     = 1'b1;
            pending_cmd_d = cmd_req;
        end

        case (state_q)
            IDLE: begin
                if (pending_q || req_take) begin
                    cmd_current_d = commit_cmd;
                    uart_sel_d    = commit_cmd;
                    pending_d     = 1'b0;
                    state_d       = LAUNCH;
                end else if (hb_cnt_q == HB_LAST) begin
                    uart_sel_d = cmd_current_q;
                    state_d    = LAUNCH;
                end else begin
                    hb_cnt_d = hb_cnt_q + HB_W'(1);
                end
            end

            LAUNCH: begin
                sender_rst_d = launch_mask;
                tmo_cnt_d    = '0;
                hb_cnt_d     = '0;
                state_d      = SEND;
            end

            SEND: begin
                if (tmo_cnt_q != TMO_LAST) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
                if (ready_unmasked) begin
                    sender_rst_d = '1;
                    gap_cnt_d    = '0;
                    state_d      = GAP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    sender_rst_d  = '1;
                    gap_cnt_d     = '0;
                    state_d       = GAP;
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    hb_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                sender_rst_d = '1;
                state_d      = IDLE;
            end
        endcase
    end

    // State registers; reset queues a STOP frame so the motors always start stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b1;
            pending_cmd_q <= '0;
            cmd_current_q <= '0;
            uart_sel_q    <= '0;
            sender_rst_q  <= '1;
            timeout_err_q <= 1'b0;
            hb_cnt_q      <= '0;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            pending_cmd_q <= pending_cmd_d;
            cmd_current_q <= cmd_current_d;
            uart_sel_q    <= uart_sel_d;
            sender_rst_q  <= sender_rst_d;
            timeout_err_q <= timeout_err_d;
            hb_cnt_q      <= hb_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        sender_rst  = sender_rst_q;
        uart_sel    = uart_sel_q;
        cmd_current = cmd_current_q;
        busy        = (state_q != IDLE);
        timeout_err = timeout_err_q;
    end

endmodule
